// File: rtl/clkx2_mc.sv
// clkx2_mc: multi-channel event-pulse CDC from clk1 to clk2 using a toggle req/ack handshake per channel.
// Latency: out pulses SYNC..SYNC+1 clk2 edges after the req toggle; the channel re-arms after one req/ack round trip.
// Backpressure: none on in; with CLKX2_MC_PEND_EN events queue in pend, otherwise or at saturation they drop and set sticky ovf.
module clkx2_mc #(
    parameter int CH     = 4,
    parameter int SYNC   = 2,
    parameter int PEND_W = 4
) (
    input  logic          rst_n,
    input  logic          clk2,
    input  logic          clk1,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] ovf,
    input  logic          ovf_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    if (CH < 1 || SYNC < 2 || PEND_W < 1) begin : g_bad_param
        $error("clkx2_mc: parameter out of range");
    end

    // Reset asserts asynchronously in both domains and releases on each domain's own clock.
    logic [1:0] rst1_q;
    logic [1:0] rst2_q;
    logic       rst1_n;
    logic       rst2_n;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) rst1_q <= 2'b00;
        else        rst1_q <= {rst1_q[0], 1'b1};
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) rst2_q <= 2'b00;
        else        rst2_q <= {rst2_q[0], 1'b1};
    end

    assign rst1_n = rst1_q[1];
    assign rst2_n = rst2_q[1];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t          state_q, state_d;
        logic            req_q, req_d;
        logic            ovf_q, ovf_d;
        logic            drop;
        logic            ack_s;
        logic [SYNC-1:0] ack_sync_q;
        logic [SYNC-1:0] req_sync_q;
        logic            rd_q;
`ifdef CLKX2_MC_PEND_EN
        logic [PEND_W-1:0] pend_q, pend_d;
`endif

        assign ack_s = ack_sync_q[SYNC-1];

        always_ff @(posedge clk1 or negedge rst1_n) begin
            if (!rst1_n) begin
                state_q    <= IDLE;
                req_q      <= 1'b0;
                ovf_q      <= 1'b0;
                ack_sync_q <= '0;
`ifdef CLKX2_MC_PEND_EN
                pend_q     <= '0;
`endif
            end else begin
                state_q    <= state_d;
                req_q      <= req_d;
                ovf_q      <= ovf_d;
                ack_sync_q <= {ack_sync_q[SYNC-2:0], rd_q};
`ifdef CLKX2_MC_PEND_EN
                pend_q     <= pend_d;
`endif
            end
        end

        always_comb begin
            state_d = state_q;
            req_d   = req_q;
            drop    = 1'b0;
`ifdef CLKX2_MC_PEND_EN
            pend_d  = pend_q;
            case (state_q)
                IDLE: begin
                    if (in[i] || pend_q != '0) begin
                        req_d   = ~req_q;
                        state_d = WAIT;
                        // A new event replaces the queued one being sent, so pend only drops when in is idle.
                        if (!in[i]) pend_d = pend_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (ack_s == req_q) state_d = IDLE;
                    if (in[i]) begin
                        if (pend_q == '1) drop   = 1'b1;
                        else              pend_d = pend_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
`else
            case (state_q)
                IDLE: begin
                    if (in[i]) begin
                        req_d   = ~req_q;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (ack_s == req_q) state_d = IDLE;
                    if (in[i]) drop = 1'b1;
                end
                default: state_d = IDLE;
            endcase
`endif
            ovf_d = drop | (ovf_q & ~ovf_clr);
        end

        always_ff @(posedge clk2 or negedge rst2_n) begin
            if (!rst2_n) begin
                req_sync_q <= '0;
                rd_q       <= 1'b0;
            end else begin
                req_sync_q <= {req_sync_q[SYNC-2:0], req_q};
                rd_q       <= req_sync_q[SYNC-1];
            end
        end

        assign out[i] = req_sync_q[SYNC-1] ^ rd_q;
        assign ovf[i] = ovf_q;
`ifdef CLKX2_MC_PEND_EN
        assign busy[i] = (state_q == WAIT) | (pend_q != '0);
`else
        assign busy[i] = (state_q == WAIT);
`endif
    end

endmodule
